// File: rtl/mole_array_controller_if.sv
// Interface bundling the game control, button and display/score signals of the
// mole array controller.
// Ports: game, buttons (driven by the player side), moles, score, misses,
// level, hit (driven by the controller). master = player side, slave = controller.
interface mole_array_controller_if #(
  parameter int NUM_MOLES = 4
);
  logic                 game;
  logic [NUM_MOLES-1:0] buttons;
  logic [NUM_MOLES-1:0] moles;
  logic [7:0]           score;
  logic [7:0]           misses;
  logic [1:0]           level;
  logic                 hit;

  modport master (
    output game, buttons,
    input  moles, score, misses, level, hit
  );

  modport slave (
    input  game, buttons,
    output moles, score, misses, level, hit
  );
endinterface

// File: rtl/mole_array_controller.sv
// Whack-a-mole controller: lights one mole at a time, scores hits, counts misses.
// Latency: all outputs registered; a hit is reported one edge after the press is sampled.
// Backpressure: none; buttons are level inputs sampled every cycle, game=0 clears everything.
// Ports: clock, reset (async, active-high), bus (slave modport: game, buttons in;
// moles, score, misses, level, hit out).
module mole_array_controller #(
  parameter int                    NUM_MOLES  = 4,
  parameter int                    LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 8'hB8,
  parameter int                    GAP_CYCLES = 150000000,
  parameter int                    SHOW_BASE  = 200000000
) (
  input logic                    clock,
  input logic                    reset,
  mole_array_controller_if.slave bus
);

  localparam int          IW       = $clog2(NUM_MOLES);
  localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] SHOW_W   = 32'(SHOW_BASE);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [NUM_MOLES-1:0] btn_prev_q, btn_prev_d;
  logic [NUM_MOLES-1:0] moles_q, moles_d;
  logic [7:0]           score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic [1:0]           level_q, level_d;
  logic                 hit_q, hit_d;
  logic [IW-1:0]        last_q, last_d;

  logic [NUM_MOLES-1:0] edges;
  logic [IW-1:0]        cand, pick;
  logic [31:0]          show_len, show_load;
  logic                 hit_now, wrong_now;

  function automatic logic [1:0] level_of(input logic [7:0] s);
    if (s <= 8'd2)       return 2'd0;
    else if (s <= 8'd5)  return 2'd1;
    else if (s <= 8'd10) return 2'd2;
    else                 return 2'd3;
  endfunction

  assign edges = bus.buttons & ~btn_prev_q;

  // A hit needs exactly one new press and it must be the lit mole; any other
  // combination of new presses during SHOW is a wrong press.
  assign hit_now   = (state_q == SHOW) && (edges != '0) && (edges == moles_q);
  assign wrong_now = (state_q == SHOW) && (edges != '0) && !hit_now;

  // Never repeat the previous mole: bump to the next position (with wrap).
  assign cand = IW'(32'(lfsr_q) % 32'(NUM_MOLES));
  assign pick = (cand != last_q)                 ? cand :
                (cand == IW'(NUM_MOLES - 1))     ? '0   : cand + IW'(1);

  // Visible time halves with each level; guard against a zero-length window.
  assign show_len  = SHOW_W >> level_q;
  assign show_load = (show_len == '0) ? '0 : show_len - 32'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_d     = lfsr_q;
    btn_prev_d = btn_prev_q;
    moles_d    = moles_q;
    score_d    = score_q;
    misses_d   = misses_q;
    level_d    = level_q;
    hit_d      = 1'b0;
    last_d     = last_q;

    if (!bus.game) begin
      state_d    = IDLE;
      cnt_d      = '0;
      lfsr_d     = '0;
      btn_prev_d = '0;
      moles_d    = '0;
      score_d    = '0;
      misses_d   = '0;
      level_d    = '0;
      last_d     = '0;
    end else begin
      // XNOR feedback keeps all-zero legal so a cleared register still runs.
      lfsr_d     = {lfsr_q[LFSR_WIDTH-2:0], ~^(lfsr_q & TAPS)};
      btn_prev_d = bus.buttons;
      level_d    = level_of(score_q);

      unique case (state_q)
        IDLE: begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            cnt_d   = show_load;
            moles_d = NUM_MOLES'(1) << pick;
            last_d  = pick;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        SHOW: begin
          if (hit_now) begin
            // Checked before the timeout so a last-cycle hit is not a miss.
            moles_d = '0;
            hit_d   = 1'b1;
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else begin
            if (wrong_now && score_q != 8'd0) score_d = score_q - 8'd1;
            if (cnt_q == '0) begin
              moles_d = '0;
              state_d = GAP;
              cnt_d   = GAP_LOAD;
              if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lfsr_q     <= '0;
      btn_prev_q <= '0;
      moles_q    <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      level_q    <= '0;
      hit_q      <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      btn_prev_q <= btn_prev_d;
      moles_q    <= moles_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      level_q    <= level_d;
      hit_q      <= hit_d;
      last_q     <= last_d;
    end
  end

  assign bus.moles  = moles_q;
  assign bus.score  = score_q;
  assign bus.misses = misses_q;
  assign bus.level  = level_q;
  assign bus.hit    = hit_q;

endmodule

// File: tb/tb_mole_array_controller.sv
// Directed bench for mole_array_controller with a small expected-value queue.
// Ports exercised: clock, reset, and the full bus interface.
module tb_mole_array_controller;

  localparam int SEL_SCORE  = 0;
  localparam int SEL_MISSES = 1;
  localparam int SEL_LEVEL  = 2;
  localparam int SEL_HIT    = 3;
  localparam int SEL_MOLES  = 4;

  logic clock = 1'b0;
  logic reset;

  mole_array_controller_if #(.NUM_MOLES(4)) bus ();

  mole_array_controller #(
    .NUM_MOLES (4),
    .LFSR_WIDTH(8),
    .TAPS      (8'hB8),
    .GAP_CYCLES(4),
    .SHOW_BASE (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   exp_score  = 0;
  int   exp_misses = 0;
  int   m_last     = 0;
  logic [7:0] m_lfsr   = 8'h00;
  logic [7:0] m_before = 8'h00;

  // Reference pseudo-random sequence: taps at bits 7,5,4,3, inverted parity in.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr   = 8'h00;
      m_before = 8'h00;
    end else begin
      m_before = m_lfsr;
      if (!bus.game) m_lfsr = 8'h00;
      else m_lfsr = {m_lfsr[6:0], !(m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3])};
    end
  end

  function automatic int lvl(input int s);
    if (s < 3) return 0;
    if (s < 6) return 1;
    if (s < 11) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_SCORE:  return 32'(bus.score);
      SEL_MISSES: return 32'(bus.misses);
      SEL_LEVEL:  return 32'(bus.level);
      SEL_HIT:    return 32'(bus.hit);
      default:    return 32'(bus.moles);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Returns on the first sample showing a lit mole; dark = dark samples seen first.
  task automatic wait_mole(output int dark);
    logic ok;
    int   c;
    dark = 0;
    ok   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (bus.moles != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      dark++;
    end
    chk("mole_appears", {31'b0, ok}, 32'd1);
    if (ok) begin
      c = int'(m_before) % 4;
      if (c == m_last) c = (c + 1) % 4;
      chk("mole_index", 32'(bus.moles), 32'(1) << c);
      m_last = c;
    end
  endtask

  // Called on a lit sample; returns on the first dark sample.
  task automatic wait_dark(output int lit);
    lit = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (bus.moles == 4'b0000) break;
      lit++;
    end
    chk("mole_clears", 32'(bus.moles), 32'd0);
  endtask

  // Press the lit mole after k further cycles and check the hit outcome.
  task automatic do_hit(input int k);
    int old;
    repeat (k) @(negedge clock);
    bus.buttons = bus.moles;
    old = exp_score;
    exp_score = (exp_score < 255) ? exp_score + 1 : 255;
    push("hit_pulse",    SEL_HIT,    32'd1);
    push("hit_score",    SEL_SCORE,  32'(exp_score));
    push("hit_moles",    SEL_MOLES,  32'd0);
    push("hit_misses",   SEL_MISSES, 32'(exp_misses));
    push("hit_level_d0", SEL_LEVEL,  32'(lvl(old)));
    @(negedge clock);
    drain();
    bus.buttons = 4'b0000;
    push("hit_pulse_end", SEL_HIT,   32'd0);
    push("hit_level_d1",  SEL_LEVEL, 32'(lvl(exp_score)));
    @(negedge clock);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int dark;
    int lit;
    logic [3:0] lit_mole;
    logic [3:0] wrong;

    reset       = 1'b1;
    bus.game    = 1'b0;
    bus.buttons = 4'b0000;
    #1;
    chk("rst_moles",  32'(bus.moles),  32'd0);
    chk("rst_score",  32'(bus.score),  32'd0);
    chk("rst_misses", 32'(bus.misses), 32'd0);
    chk("rst_level",  32'(bus.level),  32'd0);
    chk("rst_hit",    32'(bus.hit),    32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_moles", 32'(bus.moles), 32'd0);

    // Timeout round: 4 dark cycles, 16 lit cycles, one miss.
    bus.game = 1'b1;
    wait_mole(dark);
    chk("gap_len", 32'(dark), 32'd4);
    wait_dark(lit);
    chk("show_len_l0", 32'(lit), 32'd16);
    exp_misses++;
    chk("timeout_misses", 32'(bus.misses), 32'(exp_misses));
    chk("timeout_score",  32'(bus.score),  32'd0);

    // Hit on the 3rd SHOW cycle; mole index must differ from the previous one.
    wait_mole(dark);
    chk("gap_len_after_miss", 32'(dark + 1), 32'd4);
    do_hit(2);
    wait_mole(dark);
    do_hit(0);

    // Wrong (held), simultaneous, and wrong-at-zero presses in one round.
    wait_mole(dark);
    lit_mole = bus.moles;
    wrong    = {lit_mole[2:0], lit_mole[3]};
    bus.buttons = wrong;
    exp_score = (exp_score > 0) ? exp_score - 1 : 0;
    push("wrong_score", SEL_SCORE, 32'(exp_score));
    push("wrong_moles", SEL_MOLES, 32'(lit_mole));
    @(negedge clock);
    drain();
    repeat (2) begin
      @(negedge clock);
      chk("held_once_score", 32'(bus.score), 32'(exp_score));
    end
    bus.buttons = 4'b0000;
    @(negedge clock);
    bus.buttons = lit_mole | wrong;
    exp_score = (exp_score > 0) ? exp_score - 1 : 0;
    push("double_score", SEL_SCORE, 32'(exp_score));
    push("double_moles", SEL_MOLES, 32'(lit_mole));
    push("double_hit",   SEL_HIT,   32'd0);
    @(negedge clock);
    drain();
    bus.buttons = 4'b0000;
    @(negedge clock);
    bus.buttons = wrong;
    exp_score = (exp_score > 0) ? exp_score - 1 : 0;
    push("floor_score", SEL_SCORE, 32'(exp_score));
    @(negedge clock);
    drain();
    bus.buttons = 4'b0000;
    wait_dark(lit);
    exp_misses++;
    chk("wrong_round_misses", 32'(bus.misses), 32'(exp_misses));

    // Climb to score 3: level 1 halves the show time.
    repeat (3) begin
      wait_mole(dark);
      do_hit(0);
    end
    wait_mole(dark);
    wait_dark(lit);
    chk("show_len_l1", 32'(lit), 32'd8);
    exp_misses++;
    chk("l1_misses", 32'(bus.misses), 32'(exp_misses));

    // Climb to score 11: level 3 leaves a 2-cycle window.
    repeat (8) begin
      wait_mole(dark);
      do_hit(0);
    end
    chk("score_11", 32'(bus.score), 32'd11);
    wait_mole(dark);
    wait_dark(lit);
    chk("show_len_l3", 32'(lit), 32'd2);
    exp_misses++;
    chk("l3_misses", 32'(bus.misses), 32'(exp_misses));

    // Hit landing on the final SHOW cycle counts as a hit, not a miss.
    wait_mole(dark);
    do_hit(1);

    // Buttons held from GAP into SHOW produce no edge: round times out.
    bus.buttons = 4'b1111;
    wait_mole(dark);
    wait_dark(lit);
    chk("held_show_len", 32'(lit), 32'd2);
    exp_misses++;
    chk("held_misses", 32'(bus.misses), 32'(exp_misses));
    chk("held_score",  32'(bus.score),  32'(exp_score));
    bus.buttons = 4'b0000;

    // Dropping game mid-SHOW clears everything on the next edge.
    wait_mole(dark);
    bus.game = 1'b0;
    exp_score  = 0;
    exp_misses = 0;
    m_last     = 0;
    push("drop_moles",  SEL_MOLES,  32'd0);
    push("drop_score",  SEL_SCORE,  32'd0);
    push("drop_misses", SEL_MISSES, 32'd0);
    push("drop_level",  SEL_LEVEL,  32'd0);
    push("drop_hit",    SEL_HIT,    32'd0);
    @(negedge clock);
    drain();

    // Restart, score once, then assert reset in the middle of a SHOW.
    bus.game = 1'b1;
    wait_mole(dark);
    chk("restart_gap_len", 32'(dark), 32'd4);
    do_hit(0);
    wait_mole(dark);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("async_rst_moles",  32'(bus.moles),  32'd0);
    chk("async_rst_score",  32'(bus.score),  32'd0);
    chk("async_rst_misses", 32'(bus.misses), 32'd0);
    chk("async_rst_level",  32'(bus.level),  32'd0);
    exp_score  = 0;
    exp_misses = 0;
    m_last     = 0;
    @(negedge clock);
    reset = 1'b0;
    wait_mole(dark);
    chk("post_rst_gap_len", 32'(dark), 32'd4);
    chk("post_rst_score", 32'(bus.score), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mole_array_controller.md
MOLE_ARRAY_CONTROLLER -- requirements
Module: mole_array_controller

Interface
REQ-001 SHALL have parameter NUM_MOLES, default 4, number of mole positions and buttons, legal range 2..8.
REQ-002 SHALL have parameter LFSR_WIDTH, default 8, width of the pseudo-random register, legal range 3..16.
REQ-003 SHALL have parameter TAPS, default 8'hB8, LFSR tap mask, LFSR_WIDTH bits wide.
REQ-004 SHALL have parameter GAP_CYCLES, default 150000000, length of the dark interval between rounds, in cycles.
REQ-005 SHALL have parameter SHOW_BASE, default 200000000, mole visible time at level 0, in cycles.
REQ-006 SHALL have port clock, input, 1 bit; single clock, all state on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-008 SHALL have port game, input, 1 bit; 1 = game running, 0 = idle and clear.
REQ-009 SHALL have port buttons, input, NUM_MOLES bits; active-high, synchronous to clock, level signals.
REQ-010 SHALL have port moles, output, NUM_MOLES bits; one-hot or zero, registered.
REQ-011 SHALL have port score, output, 8 bits; registered.
REQ-012 SHALL have port misses, output, 8 bits; timeout count, registered.
REQ-013 SHALL have port level, output, 2 bits; difficulty level, registered.
REQ-014 SHALL have port hit, output, 1 bit; one-cycle pulse on a successful hit.

Function
REQ-015 SHALL implement states IDLE, GAP and SHOW.
REQ-016 SHALL stay in IDLE while game=0, with moles, score, misses, level, hit, counter and LFSR all cleared synchronously.
REQ-017 SHALL move IDLE->GAP on the first cycle game=1 and load the counter with GAP_CYCLES-1.
REQ-018 SHALL return to IDLE on the next edge with game=0 from any state, clearing as in REQ-016 (game has priority over all other events).
REQ-019 SHALL keep moles=0 for exactly GAP_CYCLES cycles in GAP, then enter SHOW.
REQ-020 SHALL advance the LFSR every cycle while game=1: shift left, bit0 <= XNOR-reduce(q AND TAPS); the all-zero state is legal and the all-ones state is lockup and unreachable.
REQ-021 SHALL compute the candidate index as LFSR value mod NUM_MOLES on the GAP->SHOW transition.
REQ-022 SHALL use (candidate+1) mod NUM_MOLES instead when the candidate equals the previously shown index; the previous index is 0 after IDLE.
REQ-023 SHALL assert moles[index] for exactly SHOW_BASE >> level cycles (level sampled at GAP->SHOW), unless the mole is hit first.
REQ-024 SHALL detect button presses as rising edges (registered previous value, cleared in IDLE); held buttons SHALL NOT repeat.
REQ-025 SHALL treat exactly one edge, on moles[index] during SHOW, as a hit: moles<=0, score+1 saturating at 255, hit=1 for one cycle, then GAP.
REQ-026 SHALL treat an edge on any other button, or two or more simultaneous edges, during SHOW as wrong: score-1 saturating at 0, mole stays lit, timer continues.
REQ-027 SHALL ignore button edges during GAP and IDLE.
REQ-028 SHALL, on SHOW timeout, clear moles, add 1 to misses saturating at 255, and enter GAP.
REQ-029 SHALL let a hit win over a timeout when both occur on the final SHOW cycle (no miss counted).
REQ-030 SHALL register level one cycle after score: 0 for score 0..2, 1 for 3..5, 2 for 6..10, 3 for 11 and above.
REQ-031 SHALL use a single 32-bit down-counter, and loads SHALL be N-1 so that intervals last exactly N cycles.

Reset
REQ-032 SHALL, on reset=1, immediately force state IDLE with moles=0, score=0, misses=0, level=0, hit=0, LFSR=0, counter=0 and previous-button register=0.
REQ-033 SHALL behave after reset release as REQ-016/017 (requires game=1 to start).

Verification
Parameters for the bench: NUM_MOLES=4, LFSR_WIDTH=8, TAPS=8'hB8, GAP_CYCLES=4, SHOW_BASE=16.
REQ-034 SHALL cover reset: assert reset mid-SHOW -> moles=0, score=0, misses=0 within the same cycle, no clock needed.
REQ-035 SHALL cover timeout: game=1 with no presses -> moles=0 for 4 cycles, a one-hot mole for 16 cycles, misses=1, next mole on a different index.
REQ-036 SHALL cover hit: press the lit button on the 3rd SHOW cycle -> hit pulses for 1 cycle, score=1, moles=0 next cycle, misses unchanged.
REQ-037 SHALL cover wrong and simultaneous presses: score=2, then press a wrong button -> score=1, mole stays; press two buttons at once -> score=0; press again at score=0 -> score stays 0.
REQ-038 SHALL cover level: reach score=3 -> level=1 one cycle later, next SHOW lasts 8 cycles; at score=11 SHOW lasts 2 cycles.
REQ-039 SHALL cover game drop and edges: drop game mid-SHOW -> IDLE next edge, all outputs 0; a hit on the final SHOW cycle counts as a hit with misses unchanged; a held button counts once.
